// File: rtl/oclib_pkg.sv
// rtl/oclib_pkg.sv - shared oclib constants and req/ack handshake state type
package oclib_pkg;

    localparam logic False = 1'b0;
    localparam logic True  = 1'b1;

    // Shared with the sender-side protocol checker so both ends agree on phase names.
    typedef enum logic [1:0] {
        StIdle,
        StValid,
        StAck
    } reqAckStateT;

endpackage

// File: rtl/oclib_synchronizer.sv
// rtl/oclib_synchronizer.sv - multi-flop synchronizer for asynchronous control inputs
module oclib_synchronizer #(
    parameter int Width      = 1,
    parameter int SyncCycles = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] inData,
    output logic [Width-1:0] outData
);

    logic [SyncCycles-1:0][Width-1:0] stages;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SyncCycles-2:0], inData};
        end
    end

    assign outData = stages[SyncCycles-1];

endmodule

// File: rtl/oclib_async_req_ack_to_ready_valid.sv
// rtl/oclib_async_req_ack_to_ready_valid.sv - 4-phase req/ack receiver presenting a ready/valid stream
// Optional: OCLIB_ASYNC_REQ_ACK_TO_READY_VALID_EARLY_ACK_EN acknowledges on capture instead of on transfer.
module oclib_async_req_ack_to_ready_valid
    import oclib_pkg::*;
#(
    parameter int Width      = 8,
    parameter int SyncCycles = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] inData,
    input  logic             inReq,
    output logic             inAck,
    output logic [Width-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             protocolError
);

    logic        inReqSync;
    reqAckStateT state;
    logic        acceptNow;

    oclib_synchronizer #(
        .Width     (1),
        .SyncCycles(SyncCycles)
    ) uReqSync (
        .clock  (clock),
        .reset  (reset),
        .inData (inReq),
        .outData(inReqSync)
    );

    assign acceptNow = outValid && outReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            inAck         <= False;
            outData       <= '0;
            outValid      <= False;
            protocolError <= False;
        end else begin
            case (state)
                StIdle: begin
                    // inData is only trusted once the synchronized request is seen.
                    if (inReqSync && !outValid) begin
                        outData  <= inData;
                        outValid <= True;
                        state    <= StValid;
`ifdef OCLIB_ASYNC_REQ_ACK_TO_READY_VALID_EARLY_ACK_EN
                        inAck    <= True;
`endif
                    end
                end
                StValid: begin
`ifdef OCLIB_ASYNC_REQ_ACK_TO_READY_VALID_EARLY_ACK_EN
                    // Transfer and sender release complete independently; leave only when both have.
                    if (acceptNow) begin
                        outValid <= False;
                    end
                    if (!inReqSync) begin
                        inAck <= False;
                    end
                    if ((acceptNow || !outValid) && (!inReqSync || !inAck)) begin
                        state <= StIdle;
                    end
`else
                    if (!inReqSync) begin
                        protocolError <= True;
                    end
                    if (acceptNow) begin
                        outValid <= False;
                        inAck    <= True;
                        state    <= StAck;
                    end
`endif
                end
                StAck: begin
                    // A stuck-high request simply parks here; there is no timeout.
                    if (!inReqSync) begin
                        inAck <= False;
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oclib_async_req_ack_to_ready_valid.sv
// tb/tb_oclib_async_req_ack_to_ready_valid.sv - directed self-checking bench for the req/ack receiver
module tb_oclib_async_req_ack_to_ready_valid;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inData = '0;
    logic       inReq = 1'b0;
    logic       inAck;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady = 1'b0;
    logic       protocolError;

    int vectors = 0;
    int miscompares = 0;

    oclib_async_req_ack_to_ready_valid #(
        .Width     (8),
        .SyncCycles(3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inData       (inData),
        .inReq        (inReq),
        .inAck        (inAck),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .protocolError(protocolError)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tick(2);
        check("reset_inAck", inAck, 0);
        check("reset_outValid", outValid, 0);
        check("reset_outData", outData, 0);
        check("reset_protocolError", protocolError, 0);
        reset = 1'b0;
        tick(2);

`ifdef OCLIB_ASYNC_REQ_ACK_TO_READY_VALID_EARLY_ACK_EN
        outReady = 1'b0;
        inData = 8'hC3;
        inReq = 1'b1;
        tick(3);
        check("early_not_yet", outValid, 0);
        tick(1);
        check("early_capture", {outValid, inAck, outData}, {2'b11, 8'hC3});
        inReq = 1'b0;
        tick(3);
        check("early_ack_held", inAck, 1);
        tick(1);
        check("early_ack_drop", {outValid, inAck, outData}, {2'b10, 8'hC3});
        inData = 8'hD4;
        inReq = 1'b1;
        tick(6);
        check("early_no_second_capture", {outValid, inAck, outData}, {2'b10, 8'hC3});
        outReady = 1'b1;
        tick(1);
        check("early_transfer", {outValid, inAck}, 2'b00);
        tick(1);
        check("early_second_capture", {outValid, inAck, outData}, {2'b11, 8'hD4});
        tick(1);
        check("early_second_transfer", outValid, 0);
        inReq = 1'b0;
        tick(4);
        check("early_second_release", inAck, 0);
        check("early_no_error", protocolError, 0);
`else
        // Basic round trip with outReady held high.
        outReady = 1'b1;
        inData = 8'hA5;
        inReq = 1'b1;
        tick(3);
        check("basic_latency_early", outValid, 0);
        tick(1);
        check("basic_capture", {outValid, inAck, outData}, {2'b10, 8'hA5});
        tick(1);
        check("basic_ack", {outValid, inAck}, 2'b01);
        inReq = 1'b0;
        tick(3);
        check("basic_ack_hold", inAck, 1);
        tick(1);
        check("basic_ack_release", inAck, 0);
        check("basic_no_error", protocolError, 0);

        // Backpressure: word held for 20 cycles.
        outReady = 1'b0;
        inData = 8'h3C;
        inReq = 1'b1;
        tick(4);
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {outValid, inAck, outData}, {2'b10, 8'h3C});
            tick(1);
        end
        outReady = 1'b1;
        tick(1);
        check("bp_transfer", {outValid, inAck}, 2'b01);
        tick(2);
        check("bp_single_transfer", outValid, 0);
        inReq = 1'b0;
        tick(4);
        check("bp_release", inAck, 0);

        // Back-to-back words from a behavioural sender with random outReady.
        begin
            int sent = 0;
            int got = 0;
            int senderBusy = 0;
            for (int cyc = 0; cyc < 3000 && got < 16; cyc++) begin
                if (senderBusy == 0) begin
                    if (!inAck && sent < 16) begin
                        inData = 8'(sent);
                        inReq = 1'b1;
                        senderBusy = 1;
                    end
                end else if (inAck) begin
                    inReq = 1'b0;
                    sent++;
                    senderBusy = 0;
                end
                outReady = 1'($urandom_range(0, 1));
                if (outValid && outReady) begin
                    check("b2b_data", outData, got);
                    got++;
                end
                tick(1);
            end
            check("b2b_count", got, 16);
        end
        inReq = 1'b0;
        outReady = 1'b0;
        tick(8);
        check("b2b_idle", {outValid, inAck}, 2'b00);
        check("b2b_no_error", protocolError, 0);

        // Violation: request withdrawn before the word is accepted.
        inData = 8'h5A;
        inReq = 1'b1;
        tick(4);
        check("viol_capture", {outValid, outData}, {1'b1, 8'h5A});
        inReq = 1'b0;
        tick(3);
        check("viol_not_yet", protocolError, 0);
        tick(1);
        check("viol_flag", {protocolError, outValid, outData}, {2'b11, 8'h5A});
        outReady = 1'b1;
        tick(1);
        check("viol_delivered", {outValid, inAck}, 2'b01);
        tick(1);
        check("viol_ack_release", {outValid, inAck}, 2'b00);
        tick(3);
        check("viol_sticky", {protocolError, outValid}, 2'b10);

        // Asynchronous reset while parked in StAck.
        inData = 8'h11;
        inReq = 1'b1;
        tick(5);
        check("rst_in_ack", {outValid, inAck}, 2'b01);
        #2;
        reset = 1'b1;
        inReq = 1'b0;
        #1;
        check("rst_async_clear", {inAck, outValid, protocolError}, 3'b000);
        tick(2);
        reset = 1'b0;
        inData = 8'h77;
        inReq = 1'b1;
        tick(4);
        check("rst_after_capture", {outValid, outData}, {1'b1, 8'h77});
        tick(1);
        check("rst_after_ack", {outValid, inAck}, 2'b01);
        inReq = 1'b0;
        tick(4);
        check("rst_after_release", {inAck, protocolError}, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
